// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
//   state_e           : target FSM states (IDLE, SHIFT)
//   SPI_FILL_DEFAULT  : idle MISO byte shifted out when nothing is queued
//   BYTE_W, BIT_CNT_W : byte width and bit-counter width
//   sat_inc16         : 16-bit saturating increment
package spi_target_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [7:0] SPI_FILL_DEFAULT = 8'hFF;
    localparam int         BYTE_W           = 8;
    localparam int         BIT_CNT_W        = 3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with edge detection for one asynchronous input.
//   clk, reset_n : local clock, async active-low reset
//   d            : asynchronous input
//   level        : synchronised level (last sync stage)
//   rise, fall   : single-cycle edge strobes (last stage vs. one extra delay flop)
// RESET_VAL is the idle level the chain reset to, so no spurious edge is
// seen when reset is released with the input at its idle level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    // Next-state for the synchroniser chain and the edge-detect delay flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples SCLK/CS_n/MOSI in clk, deserialises MOSI
// into bytes and serialises queued response bytes onto MISO, MSB first.
//   clk, reset_n          : local clock (>= 4x SCLK), async active-low reset
//   spi_sclk/cs_n/mosi    : SPI inputs from the controller
//   spi_miso, spi_miso_oe : MISO data and drive enable
//   tx_data/valid/ready   : one-byte response holding register (valid/ready)
//   rx_data/valid         : last received byte, one-clk strobe
//   tx_underrun           : FILL_BYTE was used for a byte after the first
//   busy                  : frame active
// Optional build macro SPI_TARGET_FRAME_CNT_EN adds frame_bytes[15:0], a
// per-frame saturating count of received bytes.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [BYTE_W-1:0] FILL_BYTE   = SPI_FILL_DEFAULT,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
`ifdef SPI_TARGET_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_bytes
`endif
);

    logic sclk_rise_s, sclk_fall_s, sclk_level_s;
    logic cs_rise_s, cs_fall_s, cs_level_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic unused_edges_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(spi_sclk),
        .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .d(spi_cs_n),
        .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );
    // Same depth as SCLK so the sampled MOSI bit lines up with the rise strobe.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(spi_mosi),
        .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );
    assign unused_edges_s = &{1'b0, mosi_rise_s, mosi_fall_s, sclk_level_s, cs_level_s};

    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]    rx_shift_q, rx_shift_d;
    // Bits still to be sent after the one currently on MISO (miso_q is shift[7]).
    logic [BYTE_W-2:0]    tx_rem_q, tx_rem_d;
    logic                 byte_done_q, byte_done_d;
    logic [BYTE_W-1:0]    hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_underrun_q, tx_underrun_d;
    logic                 miso_q, miso_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic [BYTE_W-1:0]    load_byte_s;
    logic [BYTE_W-1:0]    rx_byte_s;
    logic                 consume_s;
`ifdef SPI_TARGET_FRAME_CNT_EN
    logic [15:0]          frame_q, frame_d;
`endif

    // FSM next-state, shift datapath and tx holding-register handshake.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_rem_d      = tx_rem_q;
        byte_done_d   = byte_done_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        miso_d        = miso_q;
        oe_d          = oe_q;
        busy_d        = busy_q;
        consume_s     = 1'b0;
        load_byte_s   = hold_full_q ? hold_q : FILL_BYTE;
        rx_byte_s     = {rx_shift_q, mosi_s};
`ifdef SPI_TARGET_FRAME_CNT_EN
        frame_d       = frame_q;
`endif
        case (state_q)
            IDLE: begin
                if (cs_fall_s) begin
                    state_d     = SHIFT;
                    consume_s   = hold_full_q;
                    miso_d      = load_byte_s[BYTE_W-1];
                    tx_rem_d    = load_byte_s[BYTE_W-2:0];
                    bit_cnt_d   = {BIT_CNT_W{1'b0}};
                    byte_done_d = 1'b0;
                    oe_d        = 1'b1;
                    busy_d      = 1'b1;
`ifdef SPI_TARGET_FRAME_CNT_EN
                    frame_d     = 16'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // cs_n edges take priority over a coincident SCLK edge.
                if (cs_rise_s) begin
                    state_d     = IDLE;
                    bit_cnt_d   = {BIT_CNT_W{1'b0}};
                    byte_done_d = 1'b0;
                    oe_d        = 1'b0;
                    miso_d      = 1'b1;
                    busy_d      = 1'b0;
                end else if (sclk_rise_s) begin
                    rx_shift_d = rx_byte_s[BYTE_W-2:0];
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = rx_byte_s;
                        rx_valid_d  = 1'b1;
                        bit_cnt_d   = 3'd0;
                        byte_done_d = 1'b1;
`ifdef SPI_TARGET_FRAME_CNT_EN
                        frame_d     = sat_inc16(frame_q);
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (sclk_fall_s) begin
                    if (byte_done_q) begin
                        consume_s     = hold_full_q;
                        tx_underrun_d = ~hold_full_q;
                        miso_d        = load_byte_s[BYTE_W-1];
                        tx_rem_d      = load_byte_s[BYTE_W-2:0];
                        byte_done_d   = 1'b0;
                    end else begin
                        miso_d   = tx_rem_q[BYTE_W-2];
                        tx_rem_d = {tx_rem_q[BYTE_W-3:0], 1'b0};
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A consume only happens when holding is full, so tx_ready is low and
        // no accept can coincide; an accept into an empty holding register
        // on a load cycle leaves FILL_BYTE in the shifter.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else if (consume_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= {BIT_CNT_W{1'b0}};
            rx_shift_q    <= {(BYTE_W-1){1'b0}};
            tx_rem_q      <= {(BYTE_W-1){1'b0}};
            byte_done_q   <= 1'b0;
            hold_q        <= {BYTE_W{1'b0}};
            hold_full_q   <= 1'b0;
            rx_data_q     <= {BYTE_W{1'b0}};
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b1;
            oe_q          <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SPI_TARGET_FRAME_CNT_EN
            frame_q       <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_rem_q      <= tx_rem_d;
            byte_done_q   <= byte_done_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            busy_q        <= busy_d;
`ifdef SPI_TARGET_FRAME_CNT_EN
            frame_q       <= frame_d;
`endif
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = busy_q;
`ifdef SPI_TARGET_FRAME_CNT_EN
    assign frame_bytes = frame_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: acts as SPI controller (SCLK = clk/8),
// keeps a queue model of the response byte path and a scoreboard of
// expected received bytes that a monitor process checks on rx_valid.
`timescale 1ns/1ps
module tb_spi_target;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;
`ifdef SPI_TARGET_FRAME_CNT_EN
    logic [15:0] frame_bytes;
`endif

    spi_target dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
`ifdef SPI_TARGET_FRAME_CNT_EN
        , .frame_bytes(frame_bytes)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int underrun_seen = 0;
    logic [7:0] rx_exp_q[$];   // scoreboard: bytes the controller has sent
    logic [7:0] hold_m[$];     // model: response bytes waiting to go out

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every rx_valid must match the oldest outstanding sent byte.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid === 1'b1) begin
                if (rx_exp_q.size() == 0) check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
                else check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
            end
            if (tx_underrun === 1'b1) underrun_seen++;
        end
    end

    // Present one byte on tx_valid/tx_data until it is accepted.
    task automatic offer(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("tx_accept_timeout", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // One frame of nbytes; abort_after>0 raises cs_n after that many SCLK rises.
    task automatic run_frame(input int nbytes, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input int abort_after);
        logic [7:0] mo [3];
        logic [7:0] cap;
        logic [7:0] exp_b;
        int exp_under = 0;
        int rises = 0;
        int done_bytes = 0;
        bit aborted = 1'b0;
        mo[0] = d0; mo[1] = d1; mo[2] = d2;
        underrun_seen = 0;
        spi_cs_n = 1'b0;
        wait_clk(6);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        check("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
`ifdef SPI_TARGET_FRAME_CNT_EN
        check("frame_bytes_clear", {16'd0, frame_bytes}, 32'd0);
`endif
        for (int k = 0; k < nbytes && !aborted; k++) begin
            if (hold_m.size() > 0) exp_b = hold_m.pop_front();
            else begin
                exp_b = 8'hFF;
                if (k > 0) exp_under++;
            end
            cap = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                spi_mosi = mo[k][b];
                wait_clk(4);
                cap = {cap[6:0], spi_miso};
                if (b == 0) rx_exp_q.push_back(mo[k]);
                spi_sclk = 1'b1;
                rises++;
                wait_clk(4);
                spi_sclk = 1'b0;
                if ((abort_after != 0 && rises == abort_after) || (k == nbytes-1 && b == 0)) begin
                    spi_cs_n = 1'b1;   // same step as the SCLK fall
                end
                if (abort_after != 0 && rises == abort_after) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                check("miso_byte", {24'd0, cap}, {24'd0, exp_b});
                done_bytes++;
            end
        end
        spi_mosi = 1'b1;
        wait_clk(6);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("oe_idle", {31'd0, spi_miso_oe}, 32'd0);
        check("miso_idle", {31'd0, spi_miso}, 32'd1);
        check("underrun_count", underrun_seen, exp_under);
        check("rx_outstanding", rx_exp_q.size(), 32'd0);
        check("tx_ready_after", {31'd0, tx_ready}, {31'd0, (hold_m.size() == 0)});
`ifdef SPI_TARGET_FRAME_CNT_EN
        check("frame_bytes_end", {16'd0, frame_bytes}, done_bytes);
`endif
    endtask

    initial begin
        logic [7:0] r0, r1, r2, rq;
        int n;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(2);
        check("rst_miso", {31'd0, spi_miso}, 32'd1);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Single byte: A5 out, 3C in.
        hold_m.push_back(8'hA5);
        offer(8'hA5);
        run_frame(1, 8'h3C, 8'h00, 8'h00, 0);

        // Two bytes, only one queued: second byte is fill with one underrun.
        hold_m.push_back(8'h01);
        offer(8'h01);
        run_frame(2, 8'h81, 8'h7E, 8'h00, 0);

        // Abort after 5 rises, then a clean frame.
        run_frame(1, 8'hC3, 8'h00, 8'h00, 5);
        run_frame(1, 8'h96, 8'h00, 8'h00, 0);

        // Holding full while 55 is offered: must wait for consumption.
        hold_m.push_back(8'hA7);
        offer(8'hA7);
        check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
        hold_m.push_back(8'h55);
        fork
            offer(8'h55);
        join_none
        wait_clk(5);
        run_frame(2, 8'h12, 8'h34, 8'h00, 0);

        // Reset in the middle of a frame.
        hold_m.push_back(8'h11);
        offer(8'h11);
        spi_cs_n = 1'b0;
        wait_clk(6);
        void'(hold_m.pop_front());
        offer(8'h22);
        for (int b = 0; b < 3; b++) begin
            spi_mosi = b[0];
            wait_clk(4);
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        hold_m.delete();
        rx_exp_q.delete();
        wait_clk(4);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("mid_rst_miso", {31'd0, spi_miso}, 32'd1);
        check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);

        // Randomised frames.
        for (int i = 0; i < 10; i++) begin
            n  = $urandom_range(1, 3);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            rq = 8'($urandom);
            if ($urandom_range(0, 1) == 1 && hold_m.size() == 0) begin
                hold_m.push_back(rq);
                offer(rq);
            end
            run_frame(n, r0, r1, r2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
